// File: rtl/k423_dmem_slave_if.sv
// Purpose : request/response bundle between the EX-stage LSU (master) and
//           the data-memory responder (slave).
// Ports   : req vld/rdy, byte write-enables (all-zero = read), byte address,
//           write data; rsp vld/rdy, full-word read data, access-fault flag.
interface k423_dmem_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                mem_req_vld;
    logic                mem_req_rdy;
    logic [DATA_W/8-1:0] mem_req_wen;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic [DATA_W-1:0]   mem_req_wdata;
    logic                mem_rsp_vld;
    logic                mem_rsp_rdy;
    logic [DATA_W-1:0]   mem_rsp_rdata;
    logic                mem_rsp_err;

    modport master (
        output mem_req_vld, mem_req_wen, mem_req_addr, mem_req_wdata, mem_rsp_rdy,
        input  mem_req_rdy, mem_rsp_vld, mem_rsp_rdata, mem_rsp_err
    );

    modport slave (
        input  mem_req_vld, mem_req_wen, mem_req_addr, mem_req_wdata, mem_rsp_rdy,
        output mem_req_rdy, mem_rsp_vld, mem_rsp_rdata, mem_rsp_err
    );
endinterface

// File: rtl/k423_dmem_slave.sv
// Purpose : word-addressed data SRAM responder; byte-masked writes, in-order read responses.
// Latency : write lands at the accept edge; read valid RD_LAT edges after accept (queue empty ahead).
// Backpr. : req_rdy = credits left (cnt < RSP_DEPTH), registered only; rsp held stable while rsp_rdy=0.
// Ports   : clk_i, rst_n_i (synchronous, active-low); bus = k423_dmem_slave_if.slave.
// Option  : define K423_DMEM_ERR_EN to fault addresses outside the mapped window
//           (faulting reads return rdata=0/err=1, faulting writes are dropped);
//           otherwise the index aliases modulo DEPTH and err is always 0.
module k423_dmem_slave #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                RD_LAT    = 1,
    parameter int                RSP_DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    k423_dmem_slave_if.slave bus
);
    localparam int BYTES   = DATA_W / 8;
    localparam int IDX_LSB = $clog2(BYTES);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
`ifdef K423_DMEM_ERR_EN
    localparam logic [ADDR_W:0] RANGE_BYTES = (ADDR_W + 1)'(DEPTH * BYTES);
`endif

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] off;
    logic [IDX_W-1:0]  idx;
    logic              in_range, req_rdy, req_acc, wr_acc, rd_acc;
    logic [DATA_W-1:0] rd_word;
    logic              rd_err;
    logic              unused_off;

    // Read pipeline: stage 0 holds the word sampled at the accept edge.
    logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d, pipe_err_q, pipe_err_d;
    logic [DATA_W-1:0] pipe_dat_q [RD_LAT];
    logic [DATA_W-1:0] pipe_dat_d [RD_LAT];

    // Response queue plus credit counter covering pipeline + queue.
    logic [DATA_W-1:0]    q_dat_q [RSP_DEPTH];
    logic [DATA_W-1:0]    q_dat_d [RSP_DEPTH];
    logic [RSP_DEPTH-1:0] q_err_q, q_err_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     q_cnt_q, q_cnt_d, cnt_q, cnt_d;
    logic [DATA_W-1:0]    hold_q, hold_d;
    logic                 push, pop, rsp_vld;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Low offset bits are lane selects the LSU already handled; high bits only
    // matter for the range check.
    assign unused_off = ^off;

    assign req_rdy = (cnt_q < CNT_W'(RSP_DEPTH));

    always_comb begin
        off = bus.mem_req_addr - BASE_ADDR;
        idx = off[IDX_LSB +: IDX_W];
`ifdef K423_DMEM_ERR_EN
        in_range = ({1'b0, off} < RANGE_BYTES);
`else
        in_range = 1'b1;
`endif
        req_acc = rst_n_i & bus.mem_req_vld & req_rdy;
        wr_acc  = req_acc & (|bus.mem_req_wen) & in_range;
        rd_acc  = req_acc & ~(|bus.mem_req_wen);
        rd_word = in_range ? mem_q[idx] : '0;
        rd_err  = ~in_range;
    end

    always_comb begin
        pipe_vld_d    = '0;
        pipe_err_d    = '0;
        pipe_vld_d[0] = rd_acc;
        pipe_err_d[0] = rd_err;
        pipe_dat_d[0] = rd_word;
        for (int k = 1; k < RD_LAT; k++) begin
            pipe_vld_d[k] = pipe_vld_q[k-1];
            pipe_err_d[k] = pipe_err_q[k-1];
            pipe_dat_d[k] = pipe_dat_q[k-1];
        end
    end

    always_comb begin
        push     = pipe_vld_q[RD_LAT-1];
        rsp_vld  = (q_cnt_q != '0);
        pop      = rsp_vld & bus.mem_rsp_rdy;
        q_dat_d  = q_dat_q;
        q_err_d  = q_err_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        q_cnt_d  = q_cnt_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        // Credits guarantee the queue never overflows, so push needs no full check.
        if (push) begin
            q_dat_d[wr_ptr_q] = pipe_dat_q[RD_LAT-1];
            q_err_d[wr_ptr_q] = pipe_err_q[RD_LAT-1];
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            hold_d   = q_dat_q[rd_ptr_q];
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   q_cnt_d = q_cnt_q + CNT_W'(1);
            2'b01:   q_cnt_d = q_cnt_q - CNT_W'(1);
            default: q_cnt_d = q_cnt_q;
        endcase
        case ({rd_acc, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Memory contents survive reset; only accepted, in-range writes touch it.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            for (int i = 0; i < BYTES; i++) begin
                if (bus.mem_req_wen[i]) begin
                    mem_q[idx][8*i +: 8] <= bus.mem_req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pipe_vld_q <= '0;
            pipe_err_q <= '0;
            q_err_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            q_cnt_q    <= '0;
            cnt_q      <= '0;
            hold_q     <= '0;
            for (int k = 0; k < RD_LAT; k++)    pipe_dat_q[k] <= '0;
            for (int e = 0; e < RSP_DEPTH; e++) q_dat_q[e]    <= '0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
            pipe_err_q <= pipe_err_d;
            pipe_dat_q <= pipe_dat_d;
            q_dat_q    <= q_dat_d;
            q_err_q    <= q_err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            q_cnt_q    <= q_cnt_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
        end
    end

    assign bus.mem_req_rdy   = req_rdy;
    assign bus.mem_rsp_vld   = rsp_vld;
    // When empty, present the last word handed over rather than a stale slot.
    assign bus.mem_rsp_rdata = rsp_vld ? q_dat_q[rd_ptr_q] : hold_q;
    // Always 0 without the range check: rd_err is then constant 0.
    assign bus.mem_rsp_err   = rsp_vld & q_err_q[rd_ptr_q];
endmodule

// File: tb/tb_k423_dmem_slave.sv
module tb_k423_dmem_slave;
    localparam int          RD_LAT    = 1;
    localparam int          RSP_DEPTH = 2;
    localparam int          DEPTH     = 4096;
    localparam logic [31:0] BASE      = 32'h8000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    logic [32:0] exp_q [$];   // {err, rdata}

    k423_dmem_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    k423_dmem_slave #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE),
        .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every response must have been predicted, in order.
    always @(negedge clk) begin
        if (rst_n && bus.mem_rsp_vld) begin
            chk("rsp_spurious", 64'(exp_q.size() == 0), 64'd0);
            if (bus.mem_rsp_rdy && exp_q.size() != 0) begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("rsp_data", 64'({bus.mem_rsp_err, bus.mem_rsp_rdata}), 64'(e));
            end
        end
    end

    // Present one request until accepted; predict its response if it is a read.
    task automatic do_req(input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [32:0] exp);
        int n = 0;
        bus.mem_req_vld   = 1'b1;
        bus.mem_req_wen   = wen;
        bus.mem_req_addr  = addr;
        bus.mem_req_wdata = wdata;
        @(negedge clk);
        while (!bus.mem_req_rdy && n < 50) begin
            step();
            @(negedge clk);
            n++;
        end
        chk("req_accept", 64'(bus.mem_req_rdy), 64'd1);
        if (bus.mem_req_rdy && wen == 4'h0) exp_q.push_back(exp);
        step();
        bus.mem_req_vld = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        bus.mem_req_vld   = 1'b0;
        bus.mem_req_wen   = 4'h0;
        bus.mem_req_addr  = 32'h0;
        bus.mem_req_wdata = 32'h0;
        bus.mem_rsp_rdy   = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_rdy",   64'(bus.mem_req_rdy),   64'd1);
        chk("rst_vld",   64'(bus.mem_rsp_vld),   64'd0);
        chk("rst_rdata", 64'(bus.mem_rsp_rdata), 64'd0);
        chk("rst_err",   64'(bus.mem_rsp_err),   64'd0);
        step();
        rst_n = 1'b1;

        // T1: byte-masked write, then read with latency check
        bus.mem_rsp_rdy = 1'b1;
        do_req(4'hF,    32'h8000_0010, 32'h1111_1111, 33'h0);
        do_req(4'b0101, 32'h8000_0010, 32'hAABB_CCDD, 33'h0);
        do_req(4'h0,    32'h8000_0010, 32'h0, {1'b0, 32'h11BB_11DD});
        for (int k = 0; k < RD_LAT; k++) begin
            @(negedge clk);
            chk("t1_lat_early", 64'(bus.mem_rsp_vld), 64'd0);
            step();
        end
        @(negedge clk);
        chk("t1_lat_vld", 64'(bus.mem_rsp_vld), 64'd1);
        step();
        wait_drain();

        // T4: read the cycle after a write to the same word
        do_req(4'hF, 32'h8000_0004, 32'hDEAD_BEEF, 33'h0);
        do_req(4'h0, 32'h8000_0004, 32'h0, {1'b0, 32'hDEAD_BEEF});
        wait_drain();

        // T3: stream of reads with the sink always ready
        for (int i = 0; i < 8; i++)
            do_req(4'hF, 32'h8000_0100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 33'h0);
        for (int i = 0; i < 8; i++)
            do_req(4'h0, 32'h8000_0100 + 32'(4 * i), 32'h0, {1'b0, 32'hC0DE_0000 + 32'(i)});
        wait_drain();

        // T2: back-pressure with RSP_DEPTH outstanding reads
        bus.mem_rsp_rdy = 1'b0;
        do_req(4'hF, 32'h8000_0200, 32'hA000_0000, 33'h0);
        do_req(4'hF, 32'h8000_0204, 32'hA000_0001, 33'h0);
        do_req(4'hF, 32'h8000_0208, 32'hA000_0002, 33'h0);
        do_req(4'h0, 32'h8000_0200, 32'h0, {1'b0, 32'hA000_0000});
        do_req(4'h0, 32'h8000_0204, 32'h0, {1'b0, 32'hA000_0001});
        @(negedge clk);
        chk("t2_full_rdy", 64'(bus.mem_req_rdy), 64'd0);
        bus.mem_req_vld  = 1'b1;
        bus.mem_req_wen  = 4'h0;
        bus.mem_req_addr = 32'h8000_0208;
        repeat (3) begin
            step();
            @(negedge clk);
            chk("t2_stall_rdy", 64'(bus.mem_req_rdy),   64'd0);
            chk("t2_head_vld",  64'(bus.mem_rsp_vld),   64'd1);
            chk("t2_head_dat",  64'(bus.mem_rsp_rdata), 64'h0000_0000_A000_0000);
        end
        step();
        bus.mem_rsp_rdy = 1'b1;
        @(negedge clk);
        chk("t2_no_comb_rdy", 64'(bus.mem_req_rdy), 64'd0);
        step();
        @(negedge clk);
        chk("t2_reopen", 64'(bus.mem_req_rdy), 64'd1);
        if (bus.mem_req_rdy) exp_q.push_back({1'b0, 32'hA000_0002});
        step();
        bus.mem_req_vld = 1'b0;
        wait_drain();

        // T5: reset with two reads outstanding
        bus.mem_rsp_rdy = 1'b0;
        do_req(4'h0, 32'h8000_0200, 32'h0, {1'b0, 32'hA000_0000});
        do_req(4'h0, 32'h8000_0204, 32'h0, {1'b0, 32'hA000_0001});
        rst_n = 1'b0;
        step();
        exp_q.delete();
        @(negedge clk);
        chk("t5_vld",   64'(bus.mem_rsp_vld),   64'd0);
        chk("t5_rdy",   64'(bus.mem_req_rdy),   64'd1);
        chk("t5_rdata", 64'(bus.mem_rsp_rdata), 64'd0);
        chk("t5_err",   64'(bus.mem_rsp_err),   64'd0);
        step();
        rst_n = 1'b1;
        bus.mem_rsp_rdy = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("t5_no_stale", 64'(bus.mem_rsp_vld), 64'd0);
            step();
        end
        // memory survives reset
        do_req(4'h0, 32'h8000_0004, 32'h0, {1'b0, 32'hDEAD_BEEF});
        wait_drain();

        // T6: address below the window; top in-range word preloaded
        do_req(4'hF, 32'h8000_3FFC, 32'h5A5A_A5A5, 33'h0);
`ifdef K423_DMEM_ERR_EN
        do_req(4'h0, 32'h7FFF_FFFC, 32'h0, {1'b1, 32'h0});
        do_req(4'hF, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 33'h0);
        do_req(4'h0, 32'h8000_3FFC, 32'h0, {1'b0, 32'h5A5A_A5A5});
        do_req(4'h0, 32'h8000_4000, 32'h0, {1'b1, 32'h0});
`else
        do_req(4'h0, 32'h7FFF_FFFC, 32'h0, {1'b0, 32'h5A5A_A5A5});
        do_req(4'hF, 32'h8000_4000, 32'h1234_5678, 33'h0);
        do_req(4'h0, 32'h8000_0000, 32'h0, {1'b0, 32'h1234_5678});
`endif
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
